// File: rtl/lspc_timer_irq_pkg.sv
// Shared definitions for the LSPC raster timer: register bit positions,
// counter width and the decoded LSPCMODE timer fields.
package neo_lspc_pkg;

   localparam int unsigned LSPC_CNT_W      = 32;

   localparam int unsigned MODE_IRQ_EN_BIT = 4;
   localparam int unsigned MODE_RLD_WR_BIT = 5;
   localparam int unsigned MODE_RLD_VBL_BIT = 6;
   localparam int unsigned MODE_RLD_ZERO_BIT = 7;
   localparam int unsigned STOP_EN_BIT     = 0;

   typedef struct packed {
      logic rld_zero;
      logic rld_vbl;
      logic rld_wr;
      logic irq_en;
   } lspc_mode_t;

   typedef enum logic [1:0] {
      RLD_NONE,
      RLD_CPU,
      RLD_VBLANK,
      RLD_EXPIRY
   } rld_src_t;

   function automatic lspc_mode_t decode_mode(input logic [15:0] d);
      lspc_mode_t m;
      m.irq_en   = d[MODE_IRQ_EN_BIT];
      m.rld_wr   = d[MODE_RLD_WR_BIT];
      m.rld_vbl  = d[MODE_RLD_VBL_BIT];
      m.rld_zero = d[MODE_RLD_ZERO_BIT];
      return m;
   endfunction

endpackage

// File: rtl/lspc_timer_regs.sv
// CPU-visible timer registers: LSPCMODE timer bits, TIMERHIGH/TIMERLOW reload
// and TIMERSTOP. reload_next exposes the value including this cycle's writes.
module lspc_timer_regs
   import neo_lspc_pkg::*;
(
   input  logic        CLK,
   input  logic        nRESET,
   input  logic        WR_MODE,
   input  logic        WR_TIMER_HI,
   input  logic        WR_TIMER_LO,
   input  logic        WR_STOP,
   input  logic [15:0] M68K_DATA,
   output logic        irq_en,
   output logic        rld_wr,
   output logic        rld_vbl,
   output logic        rld_zero,
   output logic        stop_en,
   output logic [31:0] reload,
   output logic [31:0] reload_next
);

   lspc_mode_t mode_q;
   logic       stop_q;
   logic [31:0] reload_q;

   always_comb begin
      reload_next = reload_q;
      if (WR_TIMER_HI) reload_next[31:16] = M68K_DATA;
      if (WR_TIMER_LO) reload_next[15:0]  = M68K_DATA;
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         mode_q   <= '0;
         stop_q   <= 1'b0;
         reload_q <= '0;
      end else begin
         reload_q <= reload_next;
         if (WR_MODE) mode_q <= decode_mode(M68K_DATA);
         if (WR_STOP) stop_q <= M68K_DATA[STOP_EN_BIT];
      end
   end

   assign irq_en   = mode_q.irq_en;
   assign rld_wr   = mode_q.rld_wr;
   assign rld_vbl  = mode_q.rld_vbl;
   assign rld_zero = mode_q.rld_zero;
   assign stop_en  = stop_q;
   assign reload   = reload_q;

endmodule

// File: rtl/lspc_timer_irq.sv
// LSPC programmable raster timer: down-counter on the pixel clock enable with
// reload sources and a one-CLK TIMER_IRQ pulse per expiry.
module lspc_timer_irq
   import neo_lspc_pkg::*;
#(
   parameter int unsigned CNT_W = LSPC_CNT_W
) (
   input  logic             CLK,
   input  logic             nRESET,
   input  logic             PIXEL_CE,
   input  logic             VBL_START,
   input  logic             IN_BORDER,
   input  logic             WR_MODE,
   input  logic             WR_TIMER_HI,
   input  logic             WR_TIMER_LO,
   input  logic             WR_STOP,
   input  logic [15:0]      M68K_DATA,
   output logic             TIMER_IRQ,
   output logic [CNT_W-1:0] TIMER_CNT
);

   logic        irq_en;
   logic        rld_wr;
   logic        rld_vbl;
   logic        rld_zero;
   logic        stop_en;
   logic [31:0] reload;
   logic [31:0] reload_next;

   logic [CNT_W-1:0] counter;
   logic             irq_q;
   logic             tick;
   logic             expiry;
   rld_src_t         rld_src;

   lspc_timer_regs u_regs (
      .CLK         (CLK),
      .nRESET      (nRESET),
      .WR_MODE     (WR_MODE),
      .WR_TIMER_HI (WR_TIMER_HI),
      .WR_TIMER_LO (WR_TIMER_LO),
      .WR_STOP     (WR_STOP),
      .M68K_DATA   (M68K_DATA),
      .irq_en      (irq_en),
      .rld_wr      (rld_wr),
      .rld_vbl     (rld_vbl),
      .rld_zero    (rld_zero),
      .stop_en     (stop_en),
      .reload      (reload),
      .reload_next (reload_next)
   );

   // Mode bits are registered, so an LSPCMODE write in the expiry cycle
   // still sees the previous irq_en/rld_zero here.
   always_comb begin
      tick    = PIXEL_CE && !(stop_en && IN_BORDER);
      expiry  = tick && (counter == '0);
      rld_src = RLD_NONE;
      if (WR_TIMER_LO && rld_wr)   rld_src = RLD_CPU;
      else if (VBL_START && rld_vbl) rld_src = RLD_VBLANK;
      else if (expiry && rld_zero)   rld_src = RLD_EXPIRY;
   end

   // Expiry without rld_zero falls through to the decrement, which wraps 0 to all ones.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         counter <= '0;
         irq_q   <= 1'b0;
      end else begin
         irq_q <= expiry && irq_en;
         case (rld_src)
            RLD_CPU, RLD_VBLANK, RLD_EXPIRY: counter <= CNT_W'(reload_next);
            default: if (tick) counter <= counter - CNT_W'(1);
         endcase
      end
   end

   assign TIMER_IRQ = irq_q;
   assign TIMER_CNT = counter;

   logic unused_reload;
   assign unused_reload = ^reload;

endmodule

// File: tb/tb_lspc_timer_irq.sv
// Directed bench for lspc_timer_irq: IRQ pulses checked by a queue-based
// scoreboard, counter values checked against hand-computed constants.
module tb_lspc_timer_irq;

   logic        CLK;
   logic        nRESET;
   logic        PIXEL_CE;
   logic        VBL_START;
   logic        IN_BORDER;
   logic        WR_MODE;
   logic        WR_TIMER_HI;
   logic        WR_TIMER_LO;
   logic        WR_STOP;
   logic [15:0] M68K_DATA;
   logic        TIMER_IRQ;
   logic [31:0] TIMER_CNT;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;
   int unsigned exp_q[$];

   lspc_timer_irq #(.CNT_W(32)) dut (
      .CLK         (CLK),
      .nRESET      (nRESET),
      .PIXEL_CE    (PIXEL_CE),
      .VBL_START   (VBL_START),
      .IN_BORDER   (IN_BORDER),
      .WR_MODE     (WR_MODE),
      .WR_TIMER_HI (WR_TIMER_HI),
      .WR_TIMER_LO (WR_TIMER_LO),
      .WR_STOP     (WR_STOP),
      .M68K_DATA   (M68K_DATA),
      .TIMER_IRQ   (TIMER_IRQ),
      .TIMER_CNT   (TIMER_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: every IRQ pulse must match the next expected cycle stamp.
   always @(negedge CLK) begin
      if (nRESET === 1'b1 && TIMER_IRQ !== 1'b0) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL irq_unexpected: got irq=%b at cyc=%0d, want no pulse", TIMER_IRQ, cyc);
         end else begin
            int unsigned want;
            want = exp_q.pop_front();
            if (want != cyc) begin
               bad++;
               $display("FAIL irq_timing: got pulse at cyc=%0d, want cyc=%0d", cyc, want);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, want finish before timeout");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic tick(input bit exp_irq);
      PIXEL_CE = 1'b1;
      if (exp_irq) exp_q.push_back(cyc + 1);
      step();
      PIXEL_CE = 1'b0;
      step();
   endtask

   task automatic wr_mode(input logic [15:0] d);
      WR_MODE = 1'b1; M68K_DATA = d; step(); WR_MODE = 1'b0;
   endtask

   task automatic wr_hi(input logic [15:0] d);
      WR_TIMER_HI = 1'b1; M68K_DATA = d; step(); WR_TIMER_HI = 1'b0;
   endtask

   task automatic wr_lo(input logic [15:0] d);
      WR_TIMER_LO = 1'b1; M68K_DATA = d; step(); WR_TIMER_LO = 1'b0;
   endtask

   task automatic wr_stop(input logic [15:0] d);
      WR_STOP = 1'b1; M68K_DATA = d; step(); WR_STOP = 1'b0;
   endtask

   task automatic chk_cnt(input string name, input logic [31:0] want);
      total++;
      if (TIMER_CNT !== want) begin
         bad++;
         $display("FAIL %s: got cnt=%08h, want %08h", name, TIMER_CNT, want);
      end
   endtask

   task automatic chk_irq(input string name, input logic want);
      total++;
      if (TIMER_IRQ !== want) begin
         bad++;
         $display("FAIL %s: got irq=%b, want %b", name, TIMER_IRQ, want);
      end
   endtask

   task automatic drain(input string name);
      step();
      step();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s: got %0d missing irq pulses, want 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      nRESET = 1'b0; PIXEL_CE = 1'b0; VBL_START = 1'b0; IN_BORDER = 1'b0;
      WR_MODE = 1'b0; WR_TIMER_HI = 1'b0; WR_TIMER_LO = 1'b0; WR_STOP = 1'b0;
      M68K_DATA = '0;
      repeat (3) step();
      nRESET = 1'b1;
      step();
      chk_cnt("reset_cnt", 32'h0);
      chk_irq("reset_irq", 1'b0);

      // 1: reload 3, IRQ on the 4th tick
      wr_mode(16'h0030);
      wr_hi(16'h0000);
      wr_lo(16'h0003);
      chk_cnt("t1_load", 32'h3);
      tick(0); tick(0); tick(0); tick(1);
      chk_cnt("t1_wrap", 32'hFFFF_FFFF);
      drain("t1_drain");

      // 2: auto-reload 2, period 3 ticks, 5 periods
      wr_mode(16'h00B0);
      wr_lo(16'h0002);
      chk_cnt("t2_load", 32'h2);
      for (int i = 0; i < 5; i++) begin
         tick(0); tick(0); tick(1);
      end
      chk_cnt("t2_after", 32'h2);
      drain("t2_drain");

      // 3: free-running wrap
      wr_mode(16'h0030);
      wr_lo(16'h0001);
      tick(0);
      chk_cnt("t3_zero", 32'h0);
      tick(1);
      chk_cnt("t3_wrap", 32'hFFFF_FFFF);
      tick(0);
      chk_cnt("t3_dec", 32'hFFFF_FFFE);
      drain("t3_drain");

      // reload in the expiry cycle: IRQ still pulses, counter takes new low word
      wr_lo(16'h0000);
      chk_cnt("rx_zero", 32'h0);
      PIXEL_CE = 1'b1; WR_TIMER_LO = 1'b1; M68K_DATA = 16'h0005;
      exp_q.push_back(cyc + 1);
      step();
      PIXEL_CE = 1'b0; WR_TIMER_LO = 1'b0;
      step();
      chk_cnt("rx_reload", 32'h5);
      drain("rx_drain");

      // mode write in the expiry cycle: old IRQ_EN/RLD_ZERO apply
      wr_mode(16'h00B0);
      wr_lo(16'h0000);
      PIXEL_CE = 1'b1; WR_MODE = 1'b1; M68K_DATA = 16'h0000;
      exp_q.push_back(cyc + 1);
      step();
      PIXEL_CE = 1'b0; WR_MODE = 1'b0;
      step();
      chk_cnt("mx_oldmode", 32'h0);
      tick(0);
      chk_cnt("mx_newmode", 32'hFFFF_FFFF);
      drain("mx_drain");

      // 4: VBL reload
      wr_mode(16'h0030);
      wr_lo(16'h0040);
      chk_cnt("t4_load", 32'h40);
      wr_mode(16'h0050);
      wr_lo(16'h0100);
      chk_cnt("t4_noreload", 32'h40);
      repeat (9) tick(0);
      chk_cnt("t4_mid", 32'h37);
      VBL_START = 1'b1; step(); VBL_START = 1'b0;
      chk_cnt("t4_vbl", 32'h100);
      tick(0); tick(0); tick(0);
      chk_cnt("t4_dec", 32'hFD);
      VBL_START = 1'b1; PIXEL_CE = 1'b1; step();
      VBL_START = 1'b0; PIXEL_CE = 1'b0; step();
      chk_cnt("t4_vbl_tick", 32'h100);
      tick(0);
      chk_cnt("t4_resume", 32'hFF);

      // 5: stop in border
      wr_mode(16'h0030);
      wr_lo(16'h0080);
      wr_stop(16'h0001);
      IN_BORDER = 1'b1;
      repeat (50) tick(0);
      chk_cnt("t5_frozen", 32'h80);
      wr_lo(16'h0090);
      chk_cnt("t5_reload", 32'h90);
      IN_BORDER = 1'b0;
      tick(0); tick(0); tick(0);
      chk_cnt("t5_resume", 32'h8D);
      wr_stop(16'h0000);
      IN_BORDER = 1'b1;
      tick(0);
      chk_cnt("t5_nostop", 32'h8C);
      IN_BORDER = 1'b0;

      // 6: IRQ disabled, expiries silent
      wr_mode(16'h00A0);
      wr_lo(16'h0001);
      repeat (6) tick(0);
      chk_cnt("t6_cnt", 32'h1);
      drain("t6_drain");

      // reset mid-count
      wr_mode(16'h00B0);
      wr_hi(16'h1234);
      wr_lo(16'h5678);
      chk_cnt("rst_load", 32'h1234_5678);
      tick(0); tick(0);
      chk_cnt("rst_pre", 32'h1234_5676);
      nRESET = 1'b0;
      #2;
      chk_cnt("rst_cnt", 32'h0);
      chk_irq("rst_irq", 1'b0);
      step();
      nRESET = 1'b1;
      step();
      tick(0);
      chk_cnt("rst_first_exp", 32'hFFFF_FFFF);
      wr_mode(16'h0040);
      VBL_START = 1'b1; step(); VBL_START = 1'b0;
      chk_cnt("rst_reload_clr", 32'h0);
      drain("final_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
